lcd_clock_ctrl: RTL and testbench

Parametrised real-time clock core with an integrated HD44780 4-bit LCD writer. This is the successor to the fixed 12-hour clock. Time is kept internally as 24-hour BCD and is displayed in 12-hour or 24-hour format, selected at run time. Adds reset, a validated time-load port, and a per-frame time snapshot so the display never tears.

---
 rtl/lcd_clock_ctrl.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_lcd_clock_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_clock_ctrl.sv
// Real-time clock (24-hour BCD) with an HD44780 4-bit LCD writer.
// Time can be loaded through a validated port; each LCD frame shows a
// snapshot taken at its first nibble so the display never tears.
module lcd_clock_ctrl #(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned EN_CYCLES  = 800,
  parameter int unsigned INIT_WAIT  = 600000,
  parameter int unsigned CLEAR_WAIT = 24000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode24,
  input  logic       load_valid,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic       load_err,
  output logic       rs,
  output logic       en,
  output logic [3:0] data,
  output logic       pm_led
);

  localparam int unsigned PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned MaxWait = (INIT_WAIT > CLEAR_WAIT) ?
                                    ((INIT_WAIT > EN_CYCLES) ? INIT_WAIT : EN_CYCLES) :
                                    ((CLEAR_WAIT > EN_CYCLES) ? CLEAR_WAIT : EN_CYCLES);
  localparam int unsigned CW      = $clog2(MaxWait + 1);

  typedef enum logic [1:0] {StWaitPwr, StInit, StWaitClr, StFrame} state_e;

  // BCD +1 for a two-digit value; callers handle the wrap limit.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [3:0] init_nib(input logic [4:0] i);
    case (i)
      5'd0, 5'd1, 5'd2: init_nib = 4'h3;
      5'd3, 5'd4:       init_nib = 4'h2;
      5'd5:             init_nib = 4'h8;
      5'd7:             init_nib = 4'hC;
      5'd9:             init_nib = 4'h6;
      5'd11:            init_nib = 4'h1;
      default:          init_nib = 4'h0;
    endcase
  endfunction

  function automatic logic [7:0] frame_char(input logic [3:0] ci, input logic [7:0] h,
                                            input logic [7:0] m, input logic [7:0] s,
                                            input logic [15:0] sfx);
    case (ci)
      4'd0:    frame_char = {4'h3, h[7:4]};
      4'd1:    frame_char = {4'h3, h[3:0]};
      4'd3:    frame_char = {4'h3, m[7:4]};
      4'd4:    frame_char = {4'h3, m[3:0]};
      4'd6:    frame_char = {4'h3, s[7:4]};
      4'd7:    frame_char = {4'h3, s[3:0]};
      4'd2,
      4'd5:    frame_char = 8'h3A;
      4'd9:    frame_char = sfx[15:8];
      4'd10:   frame_char = sfx[7:0];
      default: frame_char = 8'h20;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Timekeeping
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic          load_err_q, load_err_d;
  logic          pm_q, pm_d;
  logic          tick, load_ok;

  assign tick    = (presc_q == PW'(CLK_HZ - 1));
  assign load_ok = (load_hh <= 8'h23) && (load_hh[3:0] <= 4'd9) &&
                   (load_mm[7:4] <= 4'd5) && (load_mm[3:0] <= 4'd9) &&
                   (load_ss[7:4] <= 4'd5) && (load_ss[3:0] <= 4'd9);

  // Next time: a valid load overrides (and discards) any tick; carries ripple.
  always_comb begin
    hh_d       = hh_q;
    mm_d       = mm_q;
    ss_d       = ss_q;
    presc_d    = tick ? '0 : presc_q + 1'b1;
    load_err_d = 1'b0;
    pm_d       = !mode24 && (hh_q >= 8'h12);
    if (load_valid && load_ok) begin
      hh_d    = load_hh;
      mm_d    = load_mm;
      ss_d    = load_ss;
      presc_d = '0;
    end else begin
      load_err_d = load_valid;
      if (tick) begin
        if (ss_q == 8'h59) begin
          ss_d = 8'h00;
          if (mm_q == 8'h59) begin
            mm_d = 8'h00;
            hh_d = (hh_q == 8'h23) ? 8'h00 : bcd_inc(hh_q);
          end else begin
            mm_d = bcd_inc(mm_q);
          end
        end else begin
          ss_d = bcd_inc(ss_q);
        end
      end
    end
  end

  // Time, prescaler and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      hh_q       <= 8'h00;
      mm_q       <= 8'h00;
      ss_q       <= 8'h00;
      load_err_q <= 1'b0;
      pm_q       <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      load_err_q <= load_err_d;
      pm_q       <= pm_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame snapshot and display formatting
  // ---------------------------------------------------------------------------
  logic [7:0]  snap_hh_q, snap_mm_q, snap_ss_q;
  logic        snap_m24_q;
  logic        snap_load;
  logic [4:0]  hbin, h12;
  logic [7:0]  hdisp;
  logic [15:0] sfx;

  // Displayed hour and suffix derived from the snapshot only.
  always_comb begin
    hbin  = 5'(snap_hh_q[7:4]) * 5'd10 + 5'(snap_hh_q[3:0]);
    h12   = hbin;
    hdisp = snap_hh_q;
    sfx   = 16'h2020;
    if (!snap_m24_q) begin
      if (hbin == 5'd0)       h12 = 5'd12;
      else if (hbin > 5'd12)  h12 = hbin - 5'd12;
      hdisp = (h12 >= 5'd10) ? {4'd1, 4'(h12 - 5'd10)} : {4'd0, 4'(h12)};
      sfx   = (hbin >= 5'd12) ? 16'h504D : 16'h414D;
    end
  end

  // Snapshot latched together with the first nibble of each frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_hh_q  <= 8'h00;
      snap_mm_q  <= 8'h00;
      snap_ss_q  <= 8'h00;
      snap_m24_q <= 1'b0;
    end else if (snap_load) begin
      snap_hh_q  <= hh_q;
      snap_mm_q  <= mm_q;
      snap_ss_q  <= ss_q;
      snap_m24_q <= mode24;
    end
  end

  // ---------------------------------------------------------------------------
  // LCD nibble sequencer
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d, ns;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    idx_q, idx_d, ni;
  logic          hi_q, hi_d;
  logic          rs_q, rs_d, en_q, en_d;
  logic [3:0]    data_q, data_d;
  logic          start;
  logic [7:0]    ch;

  // Next-state: waits, then en-high / en-low phases per nibble.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    hi_d      = hi_q;
    rs_d      = rs_q;
    en_d      = en_q;
    data_d    = data_q;
    start     = 1'b0;
    ns        = state_q;
    ni        = idx_q;
    snap_load = 1'b0;
    ch        = 8'h20;
    unique case (state_q)
      StWaitPwr: begin
        if (cnt_q == CW'(INIT_WAIT - 1)) begin
          start = 1'b1;
          ns    = StInit;
          ni    = 5'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitClr: begin
        if (cnt_q == CW'(CLEAR_WAIT - 1)) begin
          start = 1'b1;
          ns    = StFrame;
          ni    = 5'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StInit, StFrame: begin
        if (cnt_q != CW'(EN_CYCLES - 1)) begin
          cnt_d = cnt_q + 1'b1;
        end else if (hi_q) begin
          hi_d  = 1'b0;
          en_d  = 1'b0;
          cnt_d = '0;
        end else if (state_q == StInit && idx_q == 5'd11) begin
          state_d = StWaitClr;
          cnt_d   = '0;
          rs_d    = 1'b0;
          data_d  = 4'h0;
        end else begin
          start = 1'b1;
          ns    = state_q;
          ni    = (state_q == StFrame && idx_q == 5'd23) ? 5'd0 : idx_q + 5'd1;
        end
      end
      default: state_d = StWaitPwr;
    endcase

    if (start) begin
      state_d = ns;
      idx_d   = ni;
      cnt_d   = '0;
      hi_d    = 1'b1;
      en_d    = 1'b1;
      if (ns == StInit) begin
        rs_d   = 1'b0;
        data_d = init_nib(ni);
      end else if (ni < 5'd2) begin
        // DDRAM address 0x00 command; snapshot taken with its first nibble.
        rs_d      = 1'b0;
        data_d    = (ni == 5'd0) ? 4'h8 : 4'h0;
        snap_load = (ni == 5'd0);
      end else begin
        rs_d   = 1'b1;
        ch     = frame_char(4'((ni - 5'd2) >> 1), hdisp, snap_mm_q, snap_ss_q, sfx);
        data_d = ni[0] ? ch[3:0] : ch[7:4];
      end
    end
  end

  // Sequencer state and registered LCD pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWaitPwr;
      cnt_q   <= '0;
      idx_q   <= 5'd0;
      hi_q    <= 1'b0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      data_q  <= data_d;
    end
  end

  assign rs       = rs_q;
  assign en       = en_q;
  assign data     = data_q;
  assign pm_led   = pm_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_lcd_clock_ctrl.sv
// Directed bench for lcd_clock_ctrl with small parameters.
module tb_lcd_clock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode24 = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] load_hh = 8'h00, load_mm = 8'h00, load_ss = 8'h00;
  logic       load_err, rs, en, pm_led;
  logic [3:0] data;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_clock_ctrl #(
    .CLK_HZ    (10),
    .EN_CYCLES (2),
    .INIT_WAIT (20),
    .CLEAR_WAIT(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode24    (mode24),
    .load_valid(load_valid),
    .load_hh   (load_hh),
    .load_mm   (load_mm),
    .load_ss   (load_ss),
    .load_err  (load_err),
    .rs        (rs),
    .en        (en),
    .data      (data),
    .pm_led    (pm_led)
  );

  always #5 clk = ~clk;

  logic [23:0] tnow;
  assign tnow = {dut.hh_q, dut.mm_q, dut.ss_q};

  task automatic check(input string tag, input logic [87:0] obs, input logic [87:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    load_hh = h; load_mm = m; load_ss = s; load_valid = 1'b1;
    step(1);
    load_valid = 1'b0;
  endtask

  task automatic hold_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    load_hh = h; load_mm = m; load_ss = s; load_valid = 1'b1;
  endtask

  // Wait for the next en rising edge; return rs/data sampled there.
  task automatic wait_nibble(output logic r, output logic [3:0] d, output bit ok);
    logic prev;
    prev = en; ok = 1'b0; r = 1'b0; d = 4'h0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (en && !prev) begin
        ok = 1'b1; r = rs; d = data;
      end
      prev = en;
    end
    if (!ok) check("nibble_timeout", 1'b0, 1'b1);
  endtask

  // Sync to a frame (cmd 8,0 then data), releasing any held load, and
  // assemble the 11 displayed characters.
  task automatic get_frame(output logic [87:0] txt);
    logic r, p1r, p2r;
    logic [3:0] d, p1d, p2d;
    bit found, ok;
    found = 1'b0; ok = 1'b1; p1r = 1'b1; p2r = 1'b1; p1d = 4'h0; p2d = 4'h0; txt = '0;
    r = 1'b0; d = 4'h0;
    for (int i = 0; i < 60 && !found && ok; i++) begin
      wait_nibble(r, d, ok);
      if (ok && r && !p1r && !p2r && p1d == 4'h0 && p2d == 4'h8) found = 1'b1;
      else begin
        p2r = p1r; p2d = p1d; p1r = r; p1d = d;
      end
    end
    load_valid = 1'b0;
    check("frame_sync", found, 1'b1);
    if (found) begin
      txt = {txt[83:0], d};
      for (int i = 0; i < 21 && ok; i++) begin
        wait_nibble(r, d, ok);
        check("frame_rs", r, 1'b1);
        txt = {txt[83:0], d};
      end
    end
  endtask

  // From just after reset release: power-up wait, init nibbles and en width.
  task automatic init_check(input string pfx);
    int k, w;
    logic r;
    logic [3:0] d;
    logic [47:0] seq;
    bit ok, rs_all0;
    k = 0;
    for (int i = 0; i < 100 && !en; i++) begin
      @(posedge clk);
      #1;
      k++;
      if (i < 19) check({pfx, "_rs_wait"}, rs, 1'b0);
    end
    check({pfx, "_first_en_cycle"}, k, 20);
    check({pfx, "_first_data"}, data, 4'h3);
    w = 0;
    for (int i = 0; i < 20 && en; i++) begin
      @(posedge clk);
      #1;
      w++;
    end
    check({pfx, "_en_width"}, w, 2);
    seq = 48'h3; rs_all0 = 1'b1; ok = 1'b1;
    for (int i = 0; i < 11 && ok; i++) begin
      wait_nibble(r, d, ok);
      if (r) rs_all0 = 1'b0;
      seq = {seq[43:0], d};
    end
    check({pfx, "_init_seq"}, seq, 48'h333228_0C0601);
    check({pfx, "_init_rs"}, rs_all0, 1'b1);
  endtask

  logic [87:0] txt;
  logic [87:0] exp_txt;
  logic r0;
  logic [3:0] d0;
  bit ok0;

  initial begin
    // Reset state
    step(2);
    check("rst_outputs", {rs, en, data, pm_led, load_err}, 8'h00);
    check("rst_time", tnow, 24'h000000);
    rst_n = 1'b1;

    // 1: power-up and init sequence
    init_check("init");

    // 2: rollover to midnight, 24-hour display
    mode24 = 1'b1;
    do_load(8'h23, 8'h59, 8'h59);
    step(9);
    check("pre_rollover", tnow, 24'h235959);
    step(1);
    check("rollover", tnow, 24'h000000);
    check("pm_24h", pm_led, 1'b0);
    hold_load(8'h00, 8'h00, 8'h00);
    get_frame(txt);
    exp_txt = "00:00:00   ";
    check("frame_midnight_24h", txt, exp_txt);

    // 3: 12-hour display and PM indicator latency
    mode24 = 1'b0;
    do_load(8'h13, 8'h05, 8'h09);
    check("pm_before", pm_led, 1'b0);
    step(1);
    check("pm_after", pm_led, 1'b1);
    hold_load(8'h13, 8'h05, 8'h09);
    get_frame(txt);
    exp_txt = "01:05:09 PM";
    check("frame_1pm", txt, exp_txt);
    hold_load(8'h00, 8'h30, 8'h00);
    get_frame(txt);
    exp_txt = "12:30:00 AM";
    check("frame_1230am", txt, exp_txt);
    step(2);
    check("pm_am", pm_led, 1'b0);
    mode24 = 1'b1;
    hold_load(8'h13, 8'h05, 8'h09);
    get_frame(txt);
    exp_txt = "13:05:09   ";
    check("frame_13_24h", txt, exp_txt);
    step(2);
    check("pm_mode24", pm_led, 1'b0);

    // 4: rejected loads
    do_load(8'h12, 8'h00, 8'h00);
    check("valid_no_err", load_err, 1'b0);
    do_load(8'h24, 8'h00, 8'h00);
    check("err_hh", load_err, 1'b1);
    step(1);
    check("err_hh_clr", load_err, 1'b0);
    do_load(8'h12, 8'h5A, 8'h00);
    check("err_mm", load_err, 1'b1);
    step(1);
    check("err_mm_clr", load_err, 1'b0);
    do_load(8'h12, 8'h00, 8'h60);
    check("err_ss", load_err, 1'b1);
    step(1);
    check("err_ss_clr", load_err, 1'b0);
    check("err_time_kept", tnow, 24'h120000);

    // 5: load coinciding with tick
    do_load(8'h09, 8'h00, 8'h00);
    step(9);
    do_load(8'h10, 8'h00, 8'h00);
    check("load_vs_tick", tnow, 24'h100000);
    step(9);
    check("no_early_tick", tnow, 24'h100000);
    step(1);
    check("tick_after_10", tnow, 24'h100001);

    // 6: reset while en is high in a frame
    r0 = 1'b0; ok0 = 1'b1;
    for (int i = 0; i < 40 && ok0 && !r0; i++) wait_nibble(r0, d0, ok0);
    check("mid_frame_en", {r0, en}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_en", en, 1'b0);
    check("abort_data", data, 4'h0);
    check("abort_pm", pm_led, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_time", tnow, 24'h000000);
    init_check("reinit");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
